step_dir_decoder: RTL and testbench



---
 rtl/step_dir_pkg.sv | 14 +
 rtl/step_dir_decoder_if.sv | 51 +++++
 rtl/step_dir_sync.sv | 21 ++
 rtl/step_dir_decoder.sv | 162 ++++++++++++++++
 tb/tb_step_dir_decoder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/step_dir_pkg.sv
// Shared types and defaults for the step/dir receiver.
package step_dir_pkg;

    typedef enum logic [1:0] {
        StLow,
        StQual,
        StHigh
    } step_state_e;

    localparam int unsigned MinPulseDefault = 80;
    localparam int unsigned TimeoutDefault  = 50000000;
    localparam int unsigned GlitchCntBits   = 16;

endpackage

// File: rtl/step_dir_decoder_if.sv
// Pin-side and readback signals of the step/dir receiver.
// glitch_count exists only when STEP_DECODER_GLITCH_CNT_EN is defined.
interface step_dir_decoder_if #(
    parameter int unsigned PERIOD_BITS = 32,
    parameter int unsigned POS_BITS    = 32
);
    import step_dir_pkg::*;

    logic                   step_in;
    logic                   dir_in;
    logic                   pos_load;
    logic [POS_BITS-1:0]    pos_load_value;
    logic [POS_BITS-1:0]    position;
    logic [PERIOD_BITS-1:0] period;
    logic                   period_valid;
    logic                   stalled;
`ifdef STEP_DECODER_GLITCH_CNT_EN
    logic [GlitchCntBits-1:0] glitch_count;
`endif

    modport master (
        output step_in,
        output dir_in,
        output pos_load,
        output pos_load_value,
        input  position,
        input  period,
        input  period_valid,
        input  stalled
`ifdef STEP_DECODER_GLITCH_CNT_EN
        ,
        input  glitch_count
`endif
    );

    modport slave (
        input  step_in,
        input  dir_in,
        input  pos_load,
        input  pos_load_value,
        output position,
        output period,
        output period_valid,
        output stalled
`ifdef STEP_DECODER_GLITCH_CNT_EN
        ,
        output glitch_count
`endif
    );

endinterface

// File: rtl/step_dir_sync.sv
// Two-flop synchronizer for an asynchronous input line; cleared by rst.
module step_dir_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], d};
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir receiver: pulse-width qualification, signed position and step period.
// Optional glitch counter enabled by STEP_DECODER_GLITCH_CNT_EN.
module step_dir_decoder
    import step_dir_pkg::*;
#(
    parameter int unsigned PERIOD_BITS = 32,
    parameter int unsigned POS_BITS    = 32,
    parameter int unsigned MIN_PULSE   = MinPulseDefault,
    parameter int unsigned TIMEOUT     = TimeoutDefault
) (
    input  logic               clk,
    input  logic               rst,
    step_dir_decoder_if.slave  bus
);

    localparam int unsigned WIDTH_BITS = $clog2(MIN_PULSE + 1);
    localparam logic [WIDTH_BITS-1:0]  WidthLast  = WIDTH_BITS'(MIN_PULSE - 1);
    localparam logic [PERIOD_BITS-1:0] TicksMax   = '1;
    localparam logic [PERIOD_BITS-1:0] TimeoutVal = PERIOD_BITS'(TIMEOUT);

    logic step_s;
    logic dir_s;

    step_dir_sync u_step_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.step_in),
        .q   (step_s)
    );

    step_dir_sync u_dir_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.dir_in),
        .q   (dir_s)
    );

    step_state_e           state_q, state_d;
    logic [WIDTH_BITS-1:0] width_q, width_d;
    logic                  step_event;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLow;
            width_q <= '0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
        end
    end

    // width_q counts synchronized high samples seen so far in the current pulse.
    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        step_event = 1'b0;
        unique case (state_q)
            StLow: begin
                if (step_s) begin
                    width_d = WIDTH_BITS'(1);
                    if (MIN_PULSE == 1) begin
                        state_d    = StHigh;
                        step_event = 1'b1;
                    end else begin
                        state_d = StQual;
                    end
                end
            end
            StQual: begin
                if (!step_s) begin
                    state_d = StLow;
                end else begin
                    width_d = width_q + 1'b1;
                    if (width_q == WidthLast) begin
                        state_d    = StHigh;
                        step_event = 1'b1;
                    end
                end
            end
            StHigh: begin
                if (!step_s) begin
                    state_d = StLow;
                end
            end
            default: state_d = StLow;
        endcase
    end

    logic [POS_BITS-1:0]    position_q, position_d;
    logic [PERIOD_BITS-1:0] period_q, period_d;
    logic [PERIOD_BITS-1:0] ticks_q, ticks_d;
    logic                   period_valid_q, period_valid_d;
    logic                   stalled_q, stalled_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            position_q     <= '0;
            period_q       <= '0;
            ticks_q        <= '0;
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b1;
        end else begin
            position_q     <= position_d;
            period_q       <= period_d;
            ticks_q        <= ticks_d;
            period_valid_q <= period_valid_d;
            stalled_q      <= stalled_d;
        end
    end

    // The first step after a stall only re-arms the period reference.
    always_comb begin
        position_d     = position_q;
        period_d       = period_q;
        ticks_d        = ticks_q;
        period_valid_d = 1'b0;
        stalled_d      = stalled_q;
        if (step_event) begin
            ticks_d    = PERIOD_BITS'(1);
            position_d = dir_s ? position_q + POS_BITS'(1) : position_q - POS_BITS'(1);
            if (stalled_q) begin
                stalled_d = 1'b0;
            end else begin
                period_d       = ticks_q;
                period_valid_d = 1'b1;
            end
        end else begin
            if (ticks_q != TicksMax) begin
                ticks_d = ticks_q + 1'b1;
            end
            if (ticks_q >= TimeoutVal) begin
                stalled_d = 1'b1;
            end
        end
        if (bus.pos_load) begin
            position_d = bus.pos_load_value;
        end
    end

    assign bus.position     = position_q;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.stalled      = stalled_q;

`ifdef STEP_DECODER_GLITCH_CNT_EN
    logic [GlitchCntBits-1:0] glitch_q;
    logic                     qual_abort;

    assign qual_abort = (state_q == StQual) && !step_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= '0;
        end else if (qual_abort && (glitch_q != '1)) begin
            glitch_q <= glitch_q + 1'b1;
        end
    end

    assign bus.glitch_count = glitch_q;
`endif

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder with MIN_PULSE=80 and TIMEOUT=1000.
module tb_step_dir_decoder;
    import step_dir_pkg::*;

    localparam int unsigned MinPulse = 80;
    localparam int unsigned Timeout  = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    step_dir_decoder_if #(.PERIOD_BITS(32), .POS_BITS(32)) bus ();

    step_dir_decoder #(
        .PERIOD_BITS (32),
        .POS_BITS    (32),
        .MIN_PULSE   (MinPulse),
        .TIMEOUT     (Timeout)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_miss = 0;
    int          pv_cnt = 0;
    int          pv_base = 0;
    logic [31:0] last_period = '0;

    always @(negedge clk) begin
        if (bus.period_valid) begin
            pv_cnt++;
            last_period = bus.period;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic s);
        @(negedge clk);
        bus.step_in = s;
    endtask

    task automatic pulse(input int high, input int total);
        for (int i = 0; i < total; i++) tick(logic'(i < high));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.step_in  = 1'b0;
        bus.pos_load = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input logic [31:0] value);
        @(negedge clk);
        bus.pos_load       = 1'b1;
        bus.pos_load_value = value;
        @(negedge clk);
        bus.pos_load       = 1'b0;
    endtask

    initial begin
        bus.step_in        = 1'b0;
        bus.dir_in         = 1'b1;
        bus.pos_load       = 1'b0;
        bus.pos_load_value = '0;

        do_reset();
        check_eq("rst_position", bus.position, 0);
        check_eq("rst_period", bus.period, 0);
        check_eq("rst_pvalid", bus.period_valid, 0);
        check_eq("rst_stalled", bus.stalled, 1);
`ifdef STEP_DECODER_GLITCH_CNT_EN
        check_eq("rst_glitch", bus.glitch_count, 0);
`endif

        // Forward steps at 1000-cycle spacing
        pulse(160, 1000);
        check_eq("fwd1_position", bus.position, 1);
        check_eq("fwd1_stalled", bus.stalled, 0);
        check_eq("fwd1_pv", pv_cnt, 0);
        pulse(160, 1000);
        pulse(160, 1000);
        check_eq("fwd3_position", bus.position, 3);
        check_eq("fwd3_pv", pv_cnt, 2);
        check_eq("fwd3_period", last_period, 1000);

        // Reverse steps from zero
        bus.dir_in = 1'b0;
        do_reset();
        pv_base = pv_cnt;
        for (int k = 0; k < 5; k++) pulse(160, 1000);
        check_eq("rev_position", bus.position, 32'hFFFF_FFFB);
        check_eq("rev_pv", pv_cnt - pv_base, 4);

        // Short glitch, then reset in the middle of a pulse
        bus.dir_in = 1'b1;
        do_reset();
        pv_base = pv_cnt;
        pulse(40, 200);
        check_eq("glitch_position", bus.position, 0);
        check_eq("glitch_pv", pv_cnt - pv_base, 0);
        check_eq("glitch_stalled", bus.stalled, 1);
`ifdef STEP_DECODER_GLITCH_CNT_EN
        check_eq("glitch_count", bus.glitch_count, 1);
`endif
        load(32'd55);
        check_eq("load55", bus.position, 55);
        for (int i = 0; i < 60; i++) tick(1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_position", bus.position, 0);
        check_eq("midrst_stalled", bus.stalled, 1);
        check_eq("midrst_pvalid", bus.period_valid, 0);
`ifdef STEP_DECODER_GLITCH_CNT_EN
        check_eq("midrst_glitch", bus.glitch_count, 0);
`endif
        rst = 1'b0;
        for (int i = 0; i < 99; i++) tick(1'b1);
        for (int i = 0; i < 300; i++) tick(1'b0);
        check_eq("midrst_after_position", bus.position, 1);
        check_eq("midrst_after_stalled", bus.stalled, 0);
        check_eq("midrst_after_pv", pv_cnt - pv_base, 0);

        // Load exactly in the event cycle wins over the increment
        do_reset();
        pv_base = pv_cnt;
        pulse(160, 700);
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            bus.step_in        = logic'(i < 160);
            bus.pos_load       = logic'(i == MinPulse + 1);
            bus.pos_load_value = 32'd100;
        end
        bus.pos_load = 1'b0;
        check_eq("evload_position", bus.position, 100);
        check_eq("evload_pv", pv_cnt - pv_base, 1);
        check_eq("evload_period", last_period, 700);

        // Wraparound in both directions
        load(32'h7FFF_FFFF);
        pulse(160, 300);
        check_eq("wrap_up", bus.position, 32'h8000_0000);
        bus.dir_in = 1'b0;
        load(32'h0);
        pulse(160, 300);
        check_eq("wrap_down", bus.position, 32'hFFFF_FFFF);

        // Stall detection and re-arm
        bus.dir_in = 1'b1;
        do_reset();
        pv_base = pv_cnt;
        pulse(160, 500);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (i == 1081) check_eq("stall_before", bus.stalled, 0);
            if (i == 1082) check_eq("stall_rise", bus.stalled, 1);
            bus.step_in = logic'(i < 160);
        end
        check_eq("stall_pv", pv_cnt - pv_base, 1);
        check_eq("stall_period", last_period, 500);
        pulse(160, 500);
        check_eq("rearm_pv", pv_cnt - pv_base, 1);
        check_eq("rearm_stalled", bus.stalled, 0);
        check_eq("rearm_period_held", bus.period, 500);
        pulse(160, 500);
        check_eq("resume_pv", pv_cnt - pv_base, 2);
        check_eq("resume_period", last_period, 500);
        check_eq("resume_position", bus.position, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
